// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: state encoding and
// elaboration-time helpers for derived widths and parameter legality.
package dmem_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int idx_w(input int depth);
    int w = 0;
    while ((1 << w) < depth) w++;
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic bit params_legal(input int data_w, input int depth);
    return (data_w > 0) && (data_w % 8 == 0) &&
           (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W single-port storage: byte-lane write enables and a
// registered read port sharing one address.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = idx_w(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [DATA_W/8-1:0]    be,
  input  logic [IDX_W-1:0]       addr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic                   re,
  output logic [DATA_W-1:0]      rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage has no reset; zeroing is done by the controller's sweep so
  // the array can map onto plain RAM macros.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[addr];
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: valid/ready request port, 1-cycle registered
// responses, byte strobes, out-of-range errors and a post-reset zero sweep.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 16,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_done
);

  localparam int BE_W  = be_w(DATA_W);
  localparam int IDX_W = idx_w(DEPTH);

  if (!params_legal(DATA_W, DEPTH) || ADDR_W < IDX_W) begin : g_bad_params
    $error("data_mem_ctrl: illegal DATA_W/DEPTH/ADDR_W combination");
  end

  state_t             state;
  logic [IDX_W-1:0]   cnt;
  logic               ready_q;
  logic               rsp_valid_q, rsp_err_q, rd_sel_q;

  logic               accept, in_range, sweep;
  logic               arr_we, arr_re;
  logic [BE_W-1:0]    arr_be;
  logic [IDX_W-1:0]   arr_addr;
  logic [DATA_W-1:0]  arr_wdata, arr_rdata;

  // Anything presented while reset is sampled must not touch storage.
  assign accept   = req_valid && ready_q && rst_n;
  assign in_range = ({1'b0, req_addr} < (ADDR_W+1)'(DEPTH));
  assign sweep    = (state == ST_INIT) && INIT_ZERO && rst_n;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_be    = '0;
    arr_addr  = req_addr[IDX_W-1:0];
    arr_wdata = req_wdata;
    if (sweep) begin
      arr_we    = 1'b1;
      arr_be    = '1;
      arr_addr  = cnt;
      arr_wdata = '0;
    end else if (accept && in_range) begin
      arr_we = req_we;
      arr_be = req_be;
      arr_re = !req_we;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .be    (arr_be),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .re    (arr_re),
    .rdata (arr_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_INIT;
      cnt         <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_sel_q    <= 1'b0;
    end else begin
      rsp_valid_q <= accept;
      rsp_err_q   <= accept && !in_range;
      rd_sel_q    <= accept && in_range && !req_we;
      unique case (state)
        ST_INIT: begin
          if (!INIT_ZERO || cnt == IDX_W'(DEPTH - 1)) begin
            state   <= ST_RUN;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt + IDX_W'(1);
          end
        end
        ST_RUN: state <= ST_RUN;
      endcase
    end
  end

  assign req_ready = ready_q;
  assign init_done = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  // Read data is exposed only for an in-range read response.
  assign rsp_rdata = rd_sel_q ? arr_rdata : '0;

endmodule
